// File: rtl/seg_scan_scheduler.sv
// Shares one hex-to-7-segment decoder across NUM_DIGITS common-anode digits.
// Two requesters (A: game/cursor, B: score/status) write digit values through
// a round-robin arbiter; a scan FSM walks the digits and drives the pins.
// Ports:
//   clk, rst_n                               clock, async active-low reset
//   req_x, addr_x, data_x, blank_x, gnt_x    write port for requester x = a, b
//   dec_number (out), dec_segment (in)       shared decoder, both inverted/low
//   seg_out, digit_en                        registered active-low board pins
module seg_scan_scheduler #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int DIV_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_a,
    input  logic [2:0]            addr_a,
    input  logic [3:0]            data_a,
    input  logic                  blank_a,
    output logic                  gnt_a,
    input  logic                  req_b,
    input  logic [2:0]            addr_b,
    input  logic [3:0]            data_b,
    input  logic                  blank_b,
    output logic                  gnt_b,
    output logic [3:0]            dec_number,
    input  logic [6:0]            dec_segment,
    output logic [6:0]            seg_out,
    output logic [NUM_DIGITS-1:0] digit_en
);

    typedef enum logic [2:0] {
        SETUP,
        SAMPLE,
        SHOW,
        DWELL,
        GAP
    } state_t;

    localparam logic [3:0]       NDIG = 4'(NUM_DIGITS);
    localparam logic [2:0]       LAST = 3'(NUM_DIGITS - 1);
    // DWELL leaves when the incremented count reaches SCAN_DIV-1,
    // giving SCAN_DIV+3 cycles per visit in total.
    localparam logic [DIV_W-1:0] DEND = DIV_W'(SCAN_DIV - 2);

    state_t                state_q;
    state_t                state_d;
    logic [2:0]            idx_q;
    logic [DIV_W-1:0]      cnt_q;
    logic                  prio_q;
    logic [3:0]            val_q [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] blk_q;
    logic                  snap_blk_q;
    logic [3:0]            dec_q;
    logic [6:0]            seg_q;
    logic [NUM_DIGITS-1:0] en_q;

    logic                  wr_en;
    logic                  wr_hit;
    logic [2:0]            wr_addr;
    logic [3:0]            wr_data;
    logic                  wr_blank;
    logic [3:0]            cur_val;
    logic                  cur_blk;
    logic [NUM_DIGITS-1:0] lit;

    // prio_q = 0: A wins a tie; 1: B wins a tie.
    assign gnt_a = rst_n & req_a & (~req_b | ~prio_q);
    assign gnt_b = rst_n & req_b & (~req_a | prio_q);

    always_comb begin
        wr_en    = gnt_a | gnt_b;
        wr_addr  = gnt_a ? addr_a  : addr_b;
        wr_data  = gnt_a ? data_a  : data_b;
        wr_blank = gnt_a ? blank_a : blank_b;
        wr_hit   = wr_en && ({1'b0, wr_addr} < NDIG);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else if (gnt_a) begin
            prio_q <= 1'b1;
        end else if (gnt_b) begin
            prio_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                val_q[i] <= 4'h0;
            end
            blk_q <= '1;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (wr_hit && wr_addr == 3'(i)) begin
                    val_q[i] <= wr_data;
                    blk_q[i] <= wr_blank;
                end
            end
        end
    end

    always_comb begin
        cur_val = 4'h0;
        cur_blk = 1'b1;
        lit     = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == 3'(i)) begin
                cur_val = val_q[i];
                cur_blk = blk_q[i];
                lit[i]  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SETUP;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SETUP:   state_d = SAMPLE;
            SAMPLE:  state_d = SHOW;
            SHOW:    state_d = DWELL;
            DWELL: begin
                if (cnt_q == DEND) begin
                    state_d = GAP;
                end
            end
            GAP:     state_d = SETUP;
            default: state_d = SETUP;
        endcase
    end

    // dec_q doubles as the value snapshot; a write landing on the SETUP
    // edge is not seen because cur_val is read before that edge commits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q      <= 3'd0;
            cnt_q      <= '0;
            dec_q      <= 4'hF;
            snap_blk_q <= 1'b1;
            seg_q      <= 7'h7F;
            en_q       <= '1;
        end else begin
            unique case (state_q)
                SETUP: begin
                    dec_q      <= ~cur_val;
                    snap_blk_q <= cur_blk;
                end
                SAMPLE: begin
                end
                SHOW: begin
                    seg_q <= snap_blk_q ? 7'h7F : dec_segment;
                    en_q  <= snap_blk_q ? '1 : lit;
                    cnt_q <= '0;
                end
                DWELL: begin
                    cnt_q <= cnt_q + 1'b1;
                end
                GAP: begin
                    en_q  <= '1;
                    idx_q <= (idx_q == LAST) ? 3'd0 : idx_q + 3'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign dec_number = dec_q;
    assign seg_out    = seg_q;
    assign digit_en   = en_q;

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Bench for seg_scan_scheduler: random and directed writes, scan outputs
// compared each cycle against a phase-arithmetic model of the display.
module tb_seg_scan_scheduler;

    localparam int N  = 4;
    localparam int SD = 4;
    localparam int V  = SD + 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_a, req_b;
    logic [2:0] addr_a, addr_b;
    logic [3:0] data_a, data_b;
    logic       blank_a, blank_b;
    logic       gnt_a, gnt_b;
    logic [3:0] dec_number;
    logic [6:0] dec_segment;
    logic [6:0] seg_out;
    logic [3:0] digit_en;

    int checks;
    int errors;

    logic [3:0] mval [8];
    logic       mblk [8];
    logic       mprio;
    int         ecnt, mp, md;
    logic [3:0] edec, snapv, een;
    logic       snapb;
    logic [6:0] eseg;
    logic [1:0] mg;

    seg_scan_scheduler #(
        .NUM_DIGITS(N),
        .SCAN_DIV  (SD),
        .DIV_W     (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_a      (req_a),
        .addr_a     (addr_a),
        .data_a     (data_a),
        .blank_a    (blank_a),
        .gnt_a      (gnt_a),
        .req_b      (req_b),
        .addr_b     (addr_b),
        .data_b     (data_b),
        .blank_b    (blank_b),
        .gnt_b      (gnt_b),
        .dec_number (dec_number),
        .dec_segment(dec_segment),
        .seg_out    (seg_out),
        .digit_en   (digit_en)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            4'hF: return 7'h0E;
            default: return 7'h7F;
        endcase
    endfunction

    // External decoder: dec_number carries the inverted digit value.
    assign dec_segment = hex7(~dec_number);

    function automatic logic [1:0] egrant();
        return {rst_n && req_a && (!req_b || !mprio),
                rst_n && req_b && (!req_a || mprio)};
    endfunction

    // Reference: edge e since reset release is phase e%V of digit (e/V)%N.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                mval[i] = 4'h0;
                mblk[i] = 1'b1;
            end
            mprio = 1'b0;
            ecnt  = 0;
            edec  = 4'hF;
            eseg  = 7'h7F;
            een   = 4'hF;
            snapv = 4'h0;
            snapb = 1'b1;
        end else begin
            mp = ecnt % V;
            md = (ecnt / V) % N;
            if (mp == 0) begin
                snapv = mval[md];
                snapb = mblk[md];
                edec  = ~mval[md];
            end
            if (mp == 2) begin
                eseg = snapb ? 7'h7F : hex7(snapv);
                een  = snapb ? 4'hF : ~(4'b0001 << md);
            end
            if (mp == V - 1) begin
                een = 4'hF;
            end
            mg = egrant();
            if (mg[1]) begin
                if (addr_a < 3'(N)) begin
                    mval[addr_a] = data_a;
                    mblk[addr_a] = blank_a;
                end
                mprio = 1'b1;
            end else if (mg[0]) begin
                if (addr_b < 3'(N)) begin
                    mval[addr_b] = data_b;
                    mblk[addr_b] = blank_b;
                end
                mprio = 1'b0;
            end
            ecnt++;
        end
    end

    task automatic set_a(input logic r, input logic [2:0] a,
                         input logic [3:0] d, input logic b);
        req_a   = r;
        addr_a  = a;
        data_a  = d;
        blank_a = b;
    endtask

    task automatic set_b(input logic r, input logic [2:0] a,
                         input logic [3:0] d, input logic b);
        req_b   = r;
        addr_b  = a;
        data_b  = d;
        blank_b = b;
    endtask

    task automatic test_reset();
        logic [16:0] got, exp;
        #2 rst_n = 1'b0;
        set_a(1'b1, 3'd0, 4'h5, 1'b0);
        #1;
        checks++;
        if ({gnt_a, gnt_b, dec_number, seg_out, digit_en} !==
            {2'b00, 4'hF, 7'h7F, 4'hF}) begin
            errors++;
            $display("FAIL reset_async got %b want %b",
                     {gnt_a, gnt_b, dec_number, seg_out, digit_en},
                     {2'b00, 4'hF, 7'h7F, 4'hF});
        end
        @(negedge clk);
        set_a(1'b0, 3'd0, 4'h0, 1'b0);
        rst_n = 1'b1;
        for (int c = 0; c < 2 * N * V; c++) begin
            @(negedge clk);
            #1;
            got = {dec_number, seg_out, digit_en, gnt_a, gnt_b};
            exp = {edec, eseg, een, egrant()};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL reset_scan cyc %0d got %h want %h", c, got, exp);
            end
            checks++;
            if (seg_out !== 7'h7F || digit_en !== 4'hF) begin
                errors++;
                $display("FAIL reset_dark cyc %0d got %h/%b want 7f/1111",
                         c, seg_out, digit_en);
            end
        end
    endtask

    task automatic test_pattern();
        logic [16:0] got, exp;
        logic [15:0] pv;
        logic [6:0]  ws;
        logic        done;
        int          w;
        pv = 16'hFA10;
        for (int i = 0; i < N; i++) begin
            done = 1'b0;
            w = 0;
            while (!done && w < 10) begin
                @(negedge clk);
                set_a(1'b1, 3'(i), pv[i*4 +: 4], 1'b0);
                #1;
                got = {dec_number, seg_out, digit_en, gnt_a, gnt_b};
                exp = {edec, eseg, een, egrant()};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL pattern_wr addr %0d got %h want %h", i, got, exp);
                end
                done = gnt_a;
                w++;
            end
            if (!done) begin
                checks++;
                errors++;
                $display("FAIL pattern_grant addr %0d got 0 want 1", i);
            end
        end
        @(negedge clk);
        set_a(1'b0, 3'd0, 4'h0, 1'b0);
        for (int c = 0; c < 2 * N * V; c++) begin
            @(negedge clk);
            #1;
            got = {dec_number, seg_out, digit_en, gnt_a, gnt_b};
            exp = {edec, eseg, een, egrant()};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL pattern_scan cyc %0d got %h want %h", c, got, exp);
            end
            if (c >= N * V && een != 4'hF) begin
                case (een)
                    4'b1110: ws = 7'b1000000;
                    4'b1101: ws = 7'b1111001;
                    4'b1011: ws = 7'b0001000;
                    default: ws = 7'b0001110;
                endcase
                checks++;
                if (seg_out !== ws) begin
                    errors++;
                    $display("FAIL pattern_seg en %b got %b want %b", een, seg_out, ws);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] got, exp;
        logic [1:0]  wg;
        logic        done;
        int          w;
        done = 1'b0;
        w = 0;
        while (!done && w < 10) begin
            @(negedge clk);
            set_b(1'b1, 3'd0, 4'h9, 1'b0);
            #1;
            checks++;
            if (gnt_b !== 1'b1 || gnt_a !== 1'b0) begin
                errors++;
                $display("FAIL b2b_lone got %b%b want 01", gnt_a, gnt_b);
            end
            done = gnt_b;
            w++;
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            set_a(1'b1, 3'd0, 4'h5, 1'b0);
            set_b(1'b1, 3'd0, 4'h6, 1'b0);
            #1;
            wg = (k % 2 == 0) ? 2'b10 : 2'b01;
            checks++;
            if ({gnt_a, gnt_b} !== wg) begin
                errors++;
                $display("FAIL b2b_alt k %0d got %b want %b", k, {gnt_a, gnt_b}, wg);
            end
        end
        @(negedge clk);
        set_a(1'b0, 3'd0, 4'h0, 1'b0);
        set_b(1'b0, 3'd0, 4'h0, 1'b0);
        done = 1'b0;
        for (int c = 0; c < 2 * N * V; c++) begin
            @(negedge clk);
            #1;
            got = {dec_number, seg_out, digit_en, gnt_a, gnt_b};
            exp = {edec, eseg, een, egrant()};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL b2b_scan cyc %0d got %h want %h", c, got, exp);
            end
            if (c >= N * V && een == 4'b1110 && !done) begin
                done = 1'b1;
                checks++;
                if (seg_out !== 7'b0000010) begin
                    errors++;
                    $display("FAIL b2b_final got %b want 0000010", seg_out);
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL b2b_final timeout got none want digit0");
        end
    endtask

    task automatic test_oob();
        logic [16:0] got, exp;
        logic [6:0]  ws;
        @(negedge clk);
        set_a(1'b1, 3'd5, 4'h3, 1'b0);
        #1;
        checks++;
        if (gnt_a !== 1'b1) begin
            errors++;
            $display("FAIL oob_gnt_a got %b want 1", gnt_a);
        end
        @(negedge clk);
        set_a(1'b0, 3'd0, 4'h0, 1'b0);
        set_b(1'b1, 3'd7, 4'h1, 1'b1);
        #1;
        checks++;
        if (gnt_b !== 1'b1) begin
            errors++;
            $display("FAIL oob_gnt_b got %b want 1", gnt_b);
        end
        @(negedge clk);
        set_b(1'b0, 3'd0, 4'h0, 1'b0);
        for (int c = 0; c < N * V + V; c++) begin
            @(negedge clk);
            #1;
            got = {dec_number, seg_out, digit_en, gnt_a, gnt_b};
            exp = {edec, eseg, een, egrant()};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL oob_scan cyc %0d got %h want %h", c, got, exp);
            end
            if (een != 4'hF) begin
                case (een)
                    4'b1110: ws = 7'b0000010;
                    4'b1101: ws = 7'b1111001;
                    4'b1011: ws = 7'b0001000;
                    default: ws = 7'b0001110;
                endcase
                checks++;
                if (seg_out !== ws) begin
                    errors++;
                    $display("FAIL oob_seg en %b got %b want %b", een, seg_out, ws);
                end
            end
        end
    endtask

    task automatic test_rewrite();
        logic [16:0] got, exp;
        int          w, stage;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!(ecnt > 0 && (ecnt - 1) % V == 3 &&
                     ((ecnt - 1) / V) % N == 2) && w < 3 * N * V);
        set_a(1'b1, 3'd2, 4'h3, 1'b0);
        #1;
        checks++;
        if (gnt_a !== 1'b1 || digit_en !== 4'b1011) begin
            errors++;
            $display("FAIL rewrite_start got %b/%b want 1/1011", gnt_a, digit_en);
        end
        @(negedge clk);
        set_a(1'b0, 3'd0, 4'h0, 1'b0);
        stage = 0;
        for (int c = 0; c < 2 * N * V && stage < 3; c++) begin
            @(negedge clk);
            #1;
            got = {dec_number, seg_out, digit_en, gnt_a, gnt_b};
            exp = {edec, eseg, een, egrant()};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rewrite_scan cyc %0d got %h want %h", c, got, exp);
            end
            if (een == 4'b1011 && stage <= 1) begin
                stage = 1;
                checks++;
                if (seg_out !== 7'b0001000) begin
                    errors++;
                    $display("FAIL rewrite_old got %b want 0001000", seg_out);
                end
            end else if (een == 4'b1011 && stage == 2) begin
                stage = 3;
                checks++;
                if (seg_out !== 7'b0110000) begin
                    errors++;
                    $display("FAIL rewrite_new got %b want 0110000", seg_out);
                end
            end else if (een != 4'b1011 && stage == 1) begin
                stage = 2;
            end
        end
        if (stage != 3) begin
            checks++;
            errors++;
            $display("FAIL rewrite_timeout got stage %0d want 3", stage);
        end
    endtask

    task automatic test_setup_race();
        logic [16:0] got, exp;
        int          w, stage;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!(ecnt % V == 0 && (ecnt / V) % N == 3) && w < 3 * N * V);
        set_a(1'b1, 3'd3, 4'h7, 1'b0);
        #1;
        checks++;
        if (gnt_a !== 1'b1) begin
            errors++;
            $display("FAIL race_gnt got %b want 1", gnt_a);
        end
        @(negedge clk);
        set_a(1'b0, 3'd0, 4'h0, 1'b0);
        stage = 0;
        for (int c = 0; c < 3 * N * V && stage < 3; c++) begin
            @(negedge clk);
            #1;
            got = {dec_number, seg_out, digit_en, gnt_a, gnt_b};
            exp = {edec, eseg, een, egrant()};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL race_scan cyc %0d got %h want %h", c, got, exp);
            end
            if (een == 4'b0111 && stage <= 1) begin
                stage = 1;
                checks++;
                if (seg_out !== 7'b0001110) begin
                    errors++;
                    $display("FAIL race_old got %b want 0001110", seg_out);
                end
            end else if (een == 4'b0111 && stage == 2) begin
                stage = 3;
                checks++;
                if (seg_out !== 7'b1111000) begin
                    errors++;
                    $display("FAIL race_new got %b want 1111000", seg_out);
                end
            end else if (een != 4'b0111 && stage == 1) begin
                stage = 2;
            end
        end
        if (stage != 3) begin
            checks++;
            errors++;
            $display("FAIL race_timeout got stage %0d want 3", stage);
        end
    endtask

    task automatic test_reset_mid();
        logic [16:0] got, exp;
        int          w;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!(ecnt > 0 && (ecnt - 1) % V == 3 &&
                     ((ecnt - 1) / V) % N == 1) && w < 3 * N * V);
        set_a(1'b1, 3'd1, 4'h2, 1'b0);
        #1;
        checks++;
        if (digit_en !== 4'b1101) begin
            errors++;
            $display("FAIL rstmid_pre got %b want 1101", digit_en);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({digit_en, seg_out, dec_number, gnt_a} !==
            {4'hF, 7'h7F, 4'hF, 1'b0}) begin
            errors++;
            $display("FAIL rstmid_dark got %b want %b",
                     {digit_en, seg_out, dec_number, gnt_a},
                     {4'hF, 7'h7F, 4'hF, 1'b0});
        end
        @(negedge clk);
        set_a(1'b0, 3'd0, 4'h0, 1'b0);
        rst_n = 1'b1;
        for (int c = 0; c < N * V + V; c++) begin
            @(negedge clk);
            #1;
            got = {dec_number, seg_out, digit_en, gnt_a, gnt_b};
            exp = {edec, eseg, een, egrant()};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rstmid_scan cyc %0d got %h want %h", c, got, exp);
            end
            checks++;
            if (seg_out !== 7'h7F || digit_en !== 4'hF || dec_number !== 4'hF) begin
                errors++;
                $display("FAIL rstmid_blank cyc %0d got %h/%b/%h want 7f/1111/f",
                         c, seg_out, digit_en, dec_number);
            end
        end
    endtask

    task automatic test_random();
        logic [16:0] got, exp;
        logic        pa, pb;
        pa = 1'b0;
        pb = 1'b0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if (!pa) begin
                set_a($urandom_range(0, 2) != 0, 3'($urandom_range(0, 5)),
                      4'($urandom), $urandom_range(0, 3) == 0);
            end
            if (!pb) begin
                set_b($urandom_range(0, 2) != 0, 3'($urandom_range(0, 5)),
                      4'($urandom), $urandom_range(0, 3) == 0);
            end
            #1;
            got = {dec_number, seg_out, digit_en, gnt_a, gnt_b};
            exp = {edec, eseg, een, egrant()};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random cyc %0d got %h want %h", c, got, exp);
            end
            pa = req_a && !gnt_a;
            pb = req_b && !gnt_b;
        end
        @(negedge clk);
        set_a(1'b0, 3'd0, 4'h0, 1'b0);
        set_b(1'b0, 3'd0, 4'h0, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b1;
        set_a(1'b0, 3'd0, 4'h0, 1'b0);
        set_b(1'b0, 3'd0, 4'h0, 1'b0);
        test_reset();
        test_pattern();
        test_back_to_back();
        test_oob();
        test_rewrite();
        test_setup_race();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_scheduler.md
Name: seg_scan_scheduler

Overview:
- Time-multiplexes one shared hex-to-7-segment decoder across NUM_DIGITS common-anode digits.
- Holds one 4-bit value and one blank flag per digit.
- Two requesters write digit values through a round-robin arbiter: A is game/cursor logic, B is the score/status counter.
- Sits between game logic and board pins. It drives the decoder's 4-bit input, captures the decoder's 7-bit active-low output, and presents the registered segment and digit-enable pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- SCAN_DIV, 50000, dwell cycles per digit (1 ms at 50 MHz); must be >= 2.
- DIV_W, 16, width of the dwell counter; must hold SCAN_DIV-1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req_a  in  1  requester A write request.
- addr_a  in  3  requester A digit index.
- data_a  in  4  requester A hex value, 0..F.
- blank_a  in  1  requester A: 1 = digit dark.
- gnt_a  out  1  requester A grant; the write commits on this edge.
- req_b, addr_b, data_b, blank_b, gnt_b: same as the A set, for requester B.
- dec_number  out  4  to the shared decoder. Encoding is inverted: value v is driven as ~v (0 -> 4'b1111, F -> 4'b0000).
- dec_segment  in  7  decoder output, active-low, combinational from dec_number.
- seg_out  out  7  registered segment pins, active-low.
- digit_en  out  NUM_DIGITS  registered digit enables, active-low, one-hot-low or all-high.

Behaviour:
- Reset (async, rst_n=0), all effective immediately:
  - every digit value = 0 and blank = 1; seg_out = 7'h7F; digit_en all 1.
  - dec_number = 4'hF; gnt_a = gnt_b = 0.
  - state = SETUP, scan index = 0, dwell counter = 0, priority = A.
- Arbiter (combinational grant, commit on the same rising edge):
  - One write per cycle.
  - Only one requester active: that requester is granted.
  - Both active: the priority holder is granted; priority then passes to the other requester.
  - A lone grant also passes priority to the other requester.
  - Requester holds req/addr/data/blank stable until it samples gnt=1. It may keep req high for back-to-back writes.
  - addr >= NUM_DIGITS: still granted, write discarded, no state change.
  - Both requesters targeting the same addr in one cycle: only the granted one writes.
- Scan FSM. Each digit visit lasts exactly SCAN_DIV+3 cycles.
  - SETUP (1 cycle): dec_number <= ~value[scan index]; value snapshot taken here. -> SAMPLE.
  - SAMPLE (1 cycle): decoder output settles. -> SHOW.
  - SHOW (1 cycle): seg_out <= dec_segment, or 7'h7F if the snapshot blank flag = 1. digit_en <= all 1 except bit[scan index] = 0 (bit stays 1 if blank). Counter cleared. -> DWELL.
  - DWELL: counter increments each cycle; outputs held. At counter == SCAN_DIV-1 -> GAP.
  - GAP (1 cycle): digit_en <= all 1 (anti-ghosting dead time); seg_out unchanged; scan index <= index+1, wrapping NUM_DIGITS-1 -> 0. -> SETUP.
- Write/scan interaction:
  - A write to the digit currently being shown does not alter seg_out until that digit's next SETUP.
  - A write committed in the same cycle as that digit's SETUP is NOT captured; the old value is displayed for that visit.
- Outputs seg_out and digit_en only change in SHOW and GAP; they are glitch-free registers.
- Reset mid-scan or mid-grant: outputs go dark immediately; any in-flight write is lost; the requester must re-request after rst_n=1.

Test Plan:
- Reset with no requests, run 2 full scans -> digit_en stays 4'b1111 and seg_out stays 7'h7F throughout.
- A writes addr0=0, addr1=1, addr2=A, addr3=F (blank=0), SCAN_DIV=4 -> repeating 7-cycle visits:
  - dec_number 4'hF, 4'hE, 4'h5, 4'h0.
  - seg_out 7'b1000000, 7'b1111001, 7'b0001000, 7'b0001110.
  - digit_en 1110, 1101, 1011, 0111, with 1111 on every GAP cycle.
- req_a and req_b held high together for 4 cycles -> grants alternate A, B, A, B; the final value at a shared addr is from B.
- Write addr=5 (NUM_DIGITS=4) -> gnt pulses; no digit value changes; scan output unchanged.
- Rewrite digit 2 from A to 3 during its DWELL -> seg_out stays 7'b0001000 until its next SHOW, then becomes 7'b0110000.
- Deassert rst_n during DWELL of digit 1 -> same cycle, digit_en = 1111 and seg_out = 7'h7F. After release, the scan restarts at digit 0 with all digits blank.
